// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, parity-type constants and
// the 3-sample majority vote used by the bit sampler.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line and frame options in, recovered word and
// status pulses out. The receiver uses the slave modport.
interface uart_rx_if #(
  parameter int WIDTH = 8
);
  logic             rx_in;
  logic             par_en;
  logic             par_typ;
  logic [WIDTH-1:0] p_data;
  logic             data_valid;
  logic             par_err;
  logic             stop_err;

  modport master (
    output rx_in, par_en, par_typ,
    input  p_data, data_valid, par_err, stop_err
  );

  modport slave (
    input  rx_in, par_en, par_typ,
    output p_data, data_valid, par_err, stop_err
  );
endinterface

// File: rtl/rx_sampler.sv
// Line synchronizer, start-edge detector, per-bit tick counter and mid-bit
// majority vote over three consecutive synchronized samples.
module rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  input  logic active,       // FSM is inside a frame
  input  logic clear,        // FSM leaves the frame this cycle
  output logic rx_fall,
  output logic tick_wrap,
  output logic sample_valid,
  output logic sample_bit
);

  localparam int            TW     = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_CAP0 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_CAP1 = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_VOTE = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

  logic [1:0]    sync_q;
  logic          rx_s;
  logic          rx_s_d;
  logic [TW-1:0] tick_cnt;
  logic          cap_lo;
  logic          cap_mid;

  // NOTE: clocked processes use non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b11;
      rx_s_d <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rx_in};
      rx_s_d <= rx_s;
    end
  end

  assign rx_s    = sync_q[1];
  assign rx_fall = rx_s_d & ~rx_s;

  // Held at zero outside a frame so the first in-frame cycle is tick 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (!active || clear || tick_wrap) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_lo  <= 1'b1;
      cap_mid <= 1'b1;
    end else if (active) begin
      if (tick_cnt == T_CAP0) cap_lo  <= rx_s;
      if (tick_cnt == T_CAP1) cap_mid <= rx_s;
    end
  end

  // Third vote input is the live sample, so the result lands on T_VOTE.
  assign tick_wrap    = active && (tick_cnt == T_LAST);
  assign sample_valid = active && (tick_cnt == T_VOTE);
  assign sample_bit   = maj3(cap_lo, cap_mid, rx_s);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: frame FSM, bit counter, LSB-first shift register, parity
// check and registered result pulses on top of the oversampling sampler.
module uart_rx
  import uart_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int            BW       = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  rx_state_t        state_q, state_nxt;
  logic             rx_fall, tick_wrap, sample_valid, sample_bit;
  logic             frame_start, shift_en, bit_inc, par_chk, frame_end;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic             par_en_q, par_typ_q, par_flag;
  logic [WIDTH-1:0] p_data_q;
  logic             data_valid_q, par_err_q, stop_err_q;

  rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
    .clk          (clk),
    .rst          (rst),
    .rx_in        (bus.rx_in),
    .active       (state_q != IDLE),
    .clear        (state_nxt == IDLE),
    .rx_fall      (rx_fall),
    .tick_wrap    (tick_wrap),
    .sample_valid (sample_valid),
    .sample_bit   (sample_bit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_nxt;
  end

  // NOTE: default assignment first, so no path through the case infers a latch.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:   if (rx_fall) state_nxt = START;
      START: begin
        if (sample_valid && sample_bit) state_nxt = IDLE;
        else if (tick_wrap)             state_nxt = DATA;
      end
      DATA:   if (tick_wrap && bit_cnt == LAST_BIT) state_nxt = par_en_q ? PARITY : STOP;
      PARITY: if (tick_wrap) state_nxt = STOP;
      STOP:   if (sample_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    frame_start = 1'b0;
    shift_en    = 1'b0;
    bit_inc     = 1'b0;
    par_chk     = 1'b0;
    frame_end   = 1'b0;
    case (state_q)
      IDLE:   frame_start = rx_fall;
      DATA: begin
        shift_en = sample_valid;
        bit_inc  = tick_wrap;
      end
      PARITY: par_chk   = sample_valid;
      STOP:   frame_end = sample_valid;
      default: ;
    endcase
  end

  // NOTE: the shift register is reset like every other flop; a reset
  // mid-frame must leave nothing of the partial frame behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
      par_flag  <= 1'b0;
    end else begin
      if (frame_start) begin
        bit_cnt   <= '0;
        par_en_q  <= bus.par_en;
        par_typ_q <= bus.par_typ;
        par_flag  <= 1'b0;
      end
      if (bit_inc)  bit_cnt <= bit_cnt + 1'b1;
      if (shift_en) shreg   <= {sample_bit, shreg[WIDTH-1:1]};
      // Even parity bit is the XOR of the data; odd is its complement.
      if (par_chk && (sample_bit != ((^shreg) ^ (par_typ_q == PAR_ODD))))
        par_flag <= 1'b1;
    end
  end

  // A bad stop bit and a parity error are reported independently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stop_err_q   <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stop_err_q   <= 1'b0;
      if (frame_end) begin
        stop_err_q <= ~sample_bit;
        par_err_q  <= par_flag;
        if (sample_bit && !par_flag) begin
          p_data_q     <= shreg;
          data_valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.p_data     = p_data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.par_err    = par_err_q;
  assign bus.stop_err   = stop_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are predicted from the UART framing
// rules and compared event-by-event against the observed output pulses.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int OS = 8;

  typedef struct packed {
    logic       v;
    logic       pe;
    logic       se;
    logic [7:0] d;
  } ev_t;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  ev_t  got_q[$];
  ev_t  exp_q[$];
  logic [7:0] last_good = 8'h00;

  uart_rx_if #(.WIDTH(8)) bus ();

  uart_rx #(.WIDTH(8), .OVERSAMPLE(OS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // Every cycle carrying any pulse is one observed event.
  always @(negedge clk) begin
    if (rst && (bus.data_valid || bus.par_err || bus.stop_err))
      got_q.push_back(ev_t'{v: bus.data_valid, pe: bus.par_err, se: bus.stop_err, d: bus.p_data});
  end

  function automatic string fmt(input ev_t e);
    return $sformatf("v=%b pe=%b se=%b d=%02h", e.v, e.pe, e.se, e.d);
  endfunction

  task automatic drive_bit(input logic b);
    bus.rx_in = b;
    repeat (OS) @(negedge clk);
  endtask

  task automatic drive_bit_glitch(input logic b);
    bus.rx_in = b;
    repeat (OS / 2) @(negedge clk);
    bus.rx_in = ~b;
    @(negedge clk);
    bus.rx_in = b;
    repeat (OS / 2 - 1) @(negedge clk);
  endtask

  // Drives one frame and records the outcome the framing rules predict.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                            input logic bad_par, input logic stop_b, input int glitch_idx);
    logic pbit;
    logic ok;
    pbit = logic'($countones(d) % 2) ^ ptyp ^ bad_par;
    bus.par_en  = pen;
    bus.par_typ = ptyp;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_idx) drive_bit_glitch(d[i]);
      else                 drive_bit(d[i]);
    end
    if (pen) drive_bit(pbit);
    drive_bit(stop_b);
    bus.rx_in = 1'b1;
    ok = stop_b && !(pen && bad_par);
    if (ok) last_good = d;
    exp_q.push_back(ev_t'{v: ok, pe: pen && bad_par, se: !stop_b, d: last_good});
  endtask

  task automatic test_reset;
    bus.rx_in = 1'b1; bus.par_en = 1'b0; bus.par_typ = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({bus.data_valid, bus.par_err, bus.stop_err, bus.p_data} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got %b required 0", {bus.data_valid, bus.par_err, bus.stop_err, bus.p_data});
    end
    n_tests++;
    if (dut.state_q !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state got %0d required %0d", dut.state_q, IDLE);
    end
    rst = 1'b1;
    repeat (200) @(negedge clk);
    n_tests++;
    if (got_q.size() != 0) begin
      n_fail++;
      $display("FAIL idle_no_pulses got %0d events required 0", got_q.size());
    end
    n_tests++;
    if ({bus.data_valid, bus.par_err, bus.stop_err, bus.p_data} !== 11'b0) begin
      n_fail++;
      $display("FAIL idle_outputs got %b required 0", {bus.data_valid, bus.par_err, bus.stop_err, bus.p_data});
    end
    got_q.delete();
  endtask

  task automatic test_no_parity;
    send_frame(8'hA5, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1);
    repeat (20) @(negedge clk);
    n_tests++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL no_parity_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      ev_t e = exp_q.pop_front();
      ev_t g = got_q.pop_front();
      n_tests++;
      if (g !== e) begin n_fail++; $display("FAIL no_parity got %s required %s", fmt(g), fmt(e)); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_parity;
    send_frame(8'hA5, 1'b1, PAR_EVEN, 1'b0, 1'b1, -1);
    repeat (OS) @(negedge clk);
    send_frame(8'hA5, 1'b1, PAR_EVEN, 1'b1, 1'b1, -1);
    repeat (OS) @(negedge clk);
    send_frame(8'h3C, 1'b1, PAR_ODD, 1'b0, 1'b1, -1);
    repeat (20) @(negedge clk);
    n_tests++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL parity_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      ev_t e = exp_q.pop_front();
      ev_t g = got_q.pop_front();
      n_tests++;
      if (g !== e) begin n_fail++; $display("FAIL parity got %s required %s", fmt(g), fmt(e)); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_stop_err;
    send_frame(8'h5A, 1'b0, PAR_EVEN, 1'b0, 1'b0, -1);
    repeat (2 * OS) @(negedge clk);
    send_frame(8'h11, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1);
    repeat (20) @(negedge clk);
    n_tests++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL stop_err_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      ev_t e = exp_q.pop_front();
      ev_t g = got_q.pop_front();
      n_tests++;
      if (g !== e) begin n_fail++; $display("FAIL stop_err got %s required %s", fmt(g), fmt(e)); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_glitches;
    bus.rx_in = 1'b0;
    repeat (2) @(negedge clk);
    bus.rx_in = 1'b1;
    repeat (3 * OS) @(negedge clk);
    n_tests++;
    if (got_q.size() != 0 || dut.state_q !== IDLE) begin
      n_fail++;
      $display("FAIL start_glitch got %0d events state %0d required 0 events state %0d",
               got_q.size(), dut.state_q, IDLE);
    end
    got_q.delete();
    send_frame(8'hFF, 1'b0, PAR_EVEN, 1'b0, 1'b1, 3);
    repeat (20) @(negedge clk);
    n_tests++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL data_glitch_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      ev_t e = exp_q.pop_front();
      ev_t g = got_q.pop_front();
      n_tests++;
      if (g !== e) begin n_fail++; $display("FAIL data_glitch got %s required %s", fmt(g), fmt(e)); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_back_to_back;
    send_frame(8'h01, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1);
    send_frame(8'h80, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1);
    repeat (20) @(negedge clk);
    n_tests++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL back_to_back_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      ev_t e = exp_q.pop_front();
      ev_t g = got_q.pop_front();
      n_tests++;
      if (g !== e) begin n_fail++; $display("FAIL back_to_back got %s required %s", fmt(g), fmt(e)); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid;
    bus.par_en = 1'b0;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    rst = 1'b0;
    bus.rx_in = 1'b1;
    @(negedge clk);
    last_good = 8'h00;
    n_tests++;
    if ({bus.data_valid, bus.par_err, bus.stop_err, bus.p_data} !== 11'b0 || dut.state_q !== IDLE) begin
      n_fail++;
      $display("FAIL reset_mid got %b state %0d required 0 state %0d",
               {bus.data_valid, bus.par_err, bus.stop_err, bus.p_data}, dut.state_q, IDLE);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h77, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1);
    repeat (20) @(negedge clk);
    n_tests++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL reset_mid_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      ev_t e = exp_q.pop_front();
      ev_t g = got_q.pop_front();
      n_tests++;
      if (g !== e) begin n_fail++; $display("FAIL reset_mid_frame got %s required %s", fmt(g), fmt(e)); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_random;
    logic prev_bad_stop = 1'b0;
    for (int i = 0; i < 24; i++) begin
      logic [7:0] d    = 8'($urandom);
      logic       pen  = 1'($urandom_range(0, 1));
      logic       ptyp = 1'($urandom_range(0, 1));
      logic       badp = pen && ($urandom_range(0, 4) == 0);
      logic       stpb = ($urandom_range(0, 5) != 0);
      int         gap  = prev_bad_stop ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2));
      repeat (gap) drive_bit(1'b1);
      send_frame(d, pen, ptyp, badp, stpb, (i % 3 == 0) ? int'($urandom_range(0, 7)) : -1);
      prev_bad_stop = !stpb;
    end
    repeat (20) @(negedge clk);
    n_tests++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL random_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      ev_t e = exp_q.pop_front();
      ev_t g = got_q.pop_front();
      n_tests++;
      if (g !== e) begin n_fail++; $display("FAIL random got %s required %s", fmt(g), fmt(e)); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    test_reset();
    test_no_parity();
    test_parity();
    test_stop_err();
    test_glitches();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
